// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bundle: raw keyboard lines and rx_en toward the receiver,
// plus the received scan code and its status pulses back out.
interface ps2_rx_frame_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  modport master (
    output ps2c, ps2d, rx_en,
    input  dout, rx_done_tick, frame_err
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output dout, rx_done_tick, frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard frame receiver: synchronizes and deglitches the raw lines,
// shifts in 11-bit frames on filtered clock falls, and checks parity, stop bit and timeout.
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic clk,
  input logic rst,
  ps2_rx_frame_if.slave bus
);

  localparam int FCW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  logic           ps2c_s1_reg, ps2c_s2_reg;
  logic           ps2d_s1_reg, ps2d_s2_reg;
  logic [FCW-1:0] filt_cnt_reg;
  logic           filt_reg, filt_d_reg;
  logic           fall_edge;

  state_t         state_reg, state_next;
  logic [3:0]     bit_cnt_reg, bit_cnt_next;
  logic [9:0]     sh_reg, sh_next;
  logic [TCW-1:0] tmo_reg, tmo_next;
  logic [7:0]     dout_reg, dout_next;
  logic           done_reg, done_next;
  logic           err_reg, err_next;

  // Synchronizers and level filter: the filtered clock only moves after
  // FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_s1_reg  <= 1'b1;
      ps2c_s2_reg  <= 1'b1;
      ps2d_s1_reg  <= 1'b1;
      ps2d_s2_reg  <= 1'b1;
      filt_cnt_reg <= '0;
      filt_reg     <= 1'b1;
      filt_d_reg   <= 1'b1;
    end else begin
      ps2c_s1_reg <= bus.ps2c;
      ps2c_s2_reg <= ps2c_s1_reg;
      ps2d_s1_reg <= bus.ps2d;
      ps2d_s2_reg <= ps2d_s1_reg;
      filt_d_reg  <= filt_reg;
      if (ps2c_s2_reg == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_MAX) begin
        filt_reg     <= ps2c_s2_reg;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FCW'(1);
      end
    end
  end

  assign fall_edge = filt_d_reg & ~filt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      sh_reg      <= '0;
      tmo_reg     <= '0;
      dout_reg    <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      sh_reg      <= sh_next;
      tmo_reg     <= tmo_next;
      dout_reg    <= dout_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    sh_next      = sh_reg;
    tmo_next     = tmo_reg;
    dout_next    = dout_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall_edge && bus.rx_en && !ps2d_s2_reg) begin
          state_next   = SHIFT;
          bit_cnt_next = 4'd10;
          tmo_next     = '0;
          sh_next      = '0;
        end
      end
      SHIFT: begin
        if (fall_edge) begin
          // Data arrives LSB first, so each new bit enters at the top.
          sh_next      = {ps2d_s2_reg, sh_reg[9:1]};
          bit_cnt_next = bit_cnt_reg - 4'd1;
          tmo_next     = '0;
          if (bit_cnt_reg == 4'd1) begin
            state_next = LOAD;
          end
        end else if (tmo_reg == TMO_MAX) begin
          state_next = IDLE;
          err_next   = 1'b1;
          tmo_next   = '0;
        end else begin
          tmo_next = tmo_reg + TCW'(1);
        end
      end
      LOAD: begin
        state_next = IDLE;
        if (sh_reg[9] && (^sh_reg[8:0])) begin
          dout_next = sh_reg[7:0];
          done_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.dout         = dout_reg;
  assign bus.rx_done_tick = done_reg;
  assign bus.frame_err    = err_reg;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: drives PS/2 frames bit by bit and
// compares pulses and scan codes against a frame-level reference model.
module tb_ps2_rx_frame;

  localparam int FL   = 8;
  localparam int TMO  = 100;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_rx_frame_if bus();

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  bit overlap = 1'b0;
  logic [7:0] done_q[$];
  logic [7:0] exp_dout = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_q.push_back(bus.dout);
    end
    if (bus.frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.rx_done_tick === 1'b1 && bus.frame_err === 1'b1) overlap = 1'b1;
  end

  // Reference frame: start 0, data LSB first, odd parity (optionally flipped), stop.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit par_flip, input bit stop);
    logic p;
    p = ~(^d) ^ par_flip;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bus.ps2d = b;
    repeat (HALF / 2) @(posedge clk);
    #1 bus.ps2c = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(posedge clk);
    #1 bus.ps2c = 1'b1;
    repeat (HALF / 2) @(posedge clk);
  endtask

  task automatic send_range(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(f[i]);
    #1 bus.ps2d = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", bus.dout); end
    checks++;
    if (bus.rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.rx_done_tick); end
    checks++;
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.frame_err); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single;
    int d0, e0, lat;
    d0 = done_cnt; e0 = err_cnt;
    send_range(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    exp_dout = 8'h1C;
    lat = done_cyc - last_fall;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done got=%0d want=1", done_cnt - d0); end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL single_err got=%0d want=0", err_cnt - e0); end
    checks++;
    if (bus.dout !== exp_dout) begin errors++; $display("FAIL single_dout got=%h want=%h", bus.dout, exp_dout); end
    checks++;
    if (lat < FL + 3 || lat > FL + 5) begin errors++; $display("FAIL latency got=%0d want=%0d+/-1", lat, FL + 4); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] g0, g1;
    done_q.delete();
    send_range(mk_frame(8'hF0, 1'b0, 1'b1), 0, 10);
    send_range(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    exp_dout = 8'h1C;
    g0 = (done_q.size() > 0) ? done_q[0] : 8'hxx;
    g1 = (done_q.size() > 1) ? done_q[1] : 8'hxx;
    checks++;
    if (done_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", done_q.size()); end
    checks++;
    if (g0 !== 8'hF0) begin errors++; $display("FAIL b2b_first got=%h want=F0", g0); end
    checks++;
    if (g1 !== 8'h1C) begin errors++; $display("FAIL b2b_second got=%h want=1C", g1); end
  endtask

  task automatic test_parity_err;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_range(mk_frame(8'h1C, 1'b1, 1'b1), 0, 10);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL parity_err got=%0d want=1", err_cnt - e0); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL parity_done got=%0d want=0", done_cnt - d0); end
    checks++;
    if (bus.dout !== exp_dout) begin errors++; $display("FAIL parity_dout got=%h want=%h", bus.dout, exp_dout); end
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    bus.ps2d = 1'b0;
    bus.ps2c = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.ps2c = 1'b1;
    repeat (2 * TMO) @(posedge clk);
    #1 bus.ps2d = 1'b1;
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL glitch_pulses got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    send_range(mk_frame(8'h5A, 1'b0, 1'b1), 0, 10);
    exp_dout = 8'h5A;
    checks++;
    if (bus.dout !== exp_dout || done_cnt - d0 != 1) begin
      errors++; $display("FAIL glitch_next got=%h/%0d want=%h/1", bus.dout, done_cnt - d0, exp_dout);
    end
  endtask

  task automatic test_timeout;
    int d0, e0, lat;
    d0 = done_cnt; e0 = err_cnt;
    send_range(mk_frame(8'hA7, 1'b0, 1'b1), 0, 4);
    for (int i = 0; i < 4 * TMO && err_cnt == e0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    lat = err_cyc - last_fall;
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); end
    checks++;
    if (lat < TMO + FL + 1 || lat > TMO + FL + 5) begin
      errors++; $display("FAIL timeout_latency got=%0d want=%0d+/-2", lat, TMO + FL + 3);
    end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL timeout_done got=%0d want=0", done_cnt - d0); end
    send_range(mk_frame(8'h29, 1'b0, 1'b1), 0, 10);
    exp_dout = 8'h29;
    checks++;
    if (bus.dout !== exp_dout) begin errors++; $display("FAIL timeout_next got=%h want=%h", bus.dout, exp_dout); end
  endtask

  task automatic test_reset_mid;
    int d0;
    logic [10:0] f;
    f = mk_frame(8'h1C, 1'b0, 1'b1);
    d0 = done_cnt;
    send_range(f, 0, 4);
    rst = 1'b1;
    #1;
    exp_dout = 8'h00;
    checks++;
    if (bus.dout !== exp_dout) begin errors++; $display("FAIL rstmid_async got=%h want=00", bus.dout); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send_range(f, 5, 10);
    repeat (3 * TMO) @(posedge clk);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rstmid_done got=%0d want=0", done_cnt - d0); end
    checks++;
    if (bus.dout !== exp_dout) begin errors++; $display("FAIL rstmid_dout got=%h want=00", bus.dout); end
    send_range(f, 0, 10);
    exp_dout = 8'h1C;
    checks++;
    if (bus.dout !== exp_dout || done_cnt - d0 != 1) begin
      errors++; $display("FAIL rstmid_next got=%h/%0d want=%h/1", bus.dout, done_cnt - d0, exp_dout);
    end
  endtask

  task automatic test_rx_en;
    int d0, e0;
    logic [10:0] f;
    d0 = done_cnt; e0 = err_cnt;
    bus.rx_en = 1'b0;
    send_range(mk_frame(8'hFF, 1'b0, 1'b1), 0, 10);
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL rxen_off got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    bus.rx_en = 1'b1;
    f = mk_frame(8'h3C, 1'b0, 1'b1);
    send_bit(f[0]);
    bus.rx_en = 1'b0;
    send_range(f, 1, 10);
    bus.rx_en = 1'b1;
    exp_dout = 8'h3C;
    checks++;
    if (bus.dout !== exp_dout || done_cnt - d0 != 1) begin
      errors++; $display("FAIL rxen_drop got=%h/%0d want=%h/1", bus.dout, done_cnt - d0, exp_dout);
    end
  endtask

  task automatic test_random;
    int d0, e0, kind;
    logic [7:0] data;
    bit valid;
    for (int n = 0; n < 16; n++) begin
      d0 = done_cnt; e0 = err_cnt;
      data = 8'($urandom);
      kind = $urandom_range(0, 2);
      valid = (kind == 0);
      send_range(mk_frame(data, kind == 1, kind != 2), 0, 10);
      if (valid) exp_dout = data;
      checks++;
      if (done_cnt - d0 != (valid ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_done data=%h kind=%0d got=%0d want=%0d", n, data, kind, done_cnt - d0, valid ? 1 : 0);
      end
      checks++;
      if (err_cnt - e0 != (valid ? 0 : 1)) begin
        errors++; $display("FAIL rand%0d_err data=%h kind=%0d got=%0d want=%0d", n, data, kind, err_cnt - e0, valid ? 0 : 1);
      end
      checks++;
      if (bus.dout !== exp_dout) begin
        errors++; $display("FAIL rand%0d_dout got=%h want=%h", n, bus.dout, exp_dout);
      end
    end
    checks++;
    if (overlap !== 1'b0) begin errors++; $display("FAIL overlap got=%b want=0", overlap); end
  endtask

  initial begin
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    bus.rx_en = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_parity_err;
    test_glitch;
    test_timeout;
    test_reset_mid;
    test_rx_en;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
